// File: rtl/mxrx_pkg.sv
// mxrx_pkg: shared constants and types for the Manchester receive-side frame checker.
// Holds the expected-byte table also used by the transmit-side test generator.
// Latency: n/a (package). Backpressure: n/a.
package mxrx_pkg;

   // Depth of the expected-byte table; legal frame lengths are 1..MEM_SIZE.
   localparam int MEM_SIZE = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_EVAL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Expected frame contents: aa aa 0b then 04 counting up to 20h (32 decimal).
   localparam logic [7:0] MX_DEFAULT_BYTES [MEM_SIZE] = '{
      8'haa, 8'haa, 8'h0b, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
      8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10,
      8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
      8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 8'h1f, 8'h20
   };

endpackage

// File: rtl/mx_byte_rom.sv
// mx_byte_rom: expected-byte lookup, byte index -> table byte.
// Latency: combinational. Backpressure: none.
// Ports: idx (6b byte index), exp_byte (8b expected byte; 00 beyond the table).
module mx_byte_rom
   import mxrx_pkg::*;
(
   input  logic [5:0] idx,
   output logic [7:0] exp_byte
);

   always_comb begin
      exp_byte = 8'h00;
      if (idx[5] == 1'b0) begin
         exp_byte = MX_DEFAULT_BYTES[idx[4:0]];
      end
   end

endmodule

// File: rtl/mxrx_check.sv
// mxrx_check: receive-side frame checker; compares each cardet-framed byte stream with the table.
// Latency: frame_ok/frame_bad pulse 2 cycles after rx_cardet is first sampled low during a frame.
// Backpressure: none; every rx_write byte is consumed, bytes outside a checked frame are dropped.
// Ports: clk, reset (sync, active-high), length (0 = checking off), rx_data/rx_write/rx_cardet/rx_error
//   from the Manchester receiver; busy, frame_ok, frame_bad, good_count, bad_count.
// Optional: define MXRX_CHECK_FIRST_ERR_EN to add first_err_idx/first_err_data/first_err_valid,
//   which latch the position and byte of the first data mismatch since reset.
module mxrx_check
   import mxrx_pkg::*;
#(
   parameter int MEM_SIZE = mxrx_pkg::MEM_SIZE,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       length,
   input  logic [7:0]       rx_data,
   input  logic             rx_write,
   input  logic             rx_cardet,
   input  logic             rx_error,
`ifdef MXRX_CHECK_FIRST_ERR_EN
   output logic [5:0]       first_err_idx,
   output logic [7:0]       first_err_data,
   output logic             first_err_valid,
`endif
   output logic             busy,
   output logic             frame_ok,
   output logic             frame_bad,
   output logic [CNT_W-1:0] good_count,
   output logic [CNT_W-1:0] bad_count
);

   localparam logic [6:0] MEM_LIMIT = 7'(MEM_SIZE);

   state_t           state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [5:0]       len_q, len_d;
   logic             fail_q, fail_d;
   logic             armed_q, armed_d;
   logic             frame_ok_q, frame_ok_d;
   logic             frame_bad_q, frame_bad_d;
   logic [CNT_W-1:0] good_q, good_d;
   logic [CNT_W-1:0] bad_q, bad_d;
`ifdef MXRX_CHECK_FIRST_ERR_EN
   logic [5:0]       ferr_idx_q, ferr_idx_d;
   logic [7:0]       ferr_data_q, ferr_data_d;
   logic             ferr_vld_q, ferr_vld_d;
`endif

   logic [7:0] exp_byte;
   logic       byte_extra;

   mx_byte_rom u_rom (
      .idx      (idx_q),
      .exp_byte (exp_byte)
   );

   // A byte past the sampled length, or past the table, is a length failure and never advances idx.
   assign byte_extra = (idx_q >= len_q) || ({1'b0, idx_q} >= MEM_LIMIT);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      fail_d      = fail_q;
      good_d      = good_q;
      bad_d       = bad_q;
      frame_ok_d  = 1'b0;
      frame_bad_d = 1'b0;
      // After reset a frame already in flight must end before a new check may start.
      armed_d     = armed_q | ~rx_cardet;
`ifdef MXRX_CHECK_FIRST_ERR_EN
      ferr_idx_d  = ferr_idx_q;
      ferr_data_d = ferr_data_q;
      ferr_vld_d  = ferr_vld_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (rx_cardet && armed_q) begin
               if (length == 6'd0) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RECV;
                  idx_d   = 6'd0;
                  fail_d  = 1'b0;
                  len_d   = length;
               end
            end
         end

         ST_RECV: begin
            if (rx_write) begin
               if (byte_extra) begin
                  fail_d = 1'b1;
               end else begin
                  idx_d = idx_q + 6'd1;
                  if (rx_data != exp_byte) begin
                     fail_d = 1'b1;
`ifdef MXRX_CHECK_FIRST_ERR_EN
                     if (!ferr_vld_q) begin
                        ferr_vld_d  = 1'b1;
                        ferr_idx_d  = idx_q;
                        ferr_data_d = rx_data;
                     end
`endif
                  end
               end
            end
            if (rx_error) begin
               fail_d = 1'b1;
            end
            // A byte arriving on the same cycle cardet drops is still checked above.
            if (!rx_cardet) begin
               state_d = ST_EVAL;
            end
         end

         ST_EVAL: begin
            if (fail_q || (idx_q != len_q)) begin
               frame_bad_d = 1'b1;
               if (bad_q != {CNT_W{1'b1}}) begin
                  bad_d = bad_q + 1'b1;
               end
            end else begin
               frame_ok_d = 1'b1;
               if (good_q != {CNT_W{1'b1}}) begin
                  good_d = good_q + 1'b1;
               end
            end
            state_d = ST_IDLE;
         end

         ST_DRAIN: begin
            if (!rx_cardet) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= 6'd0;
         len_q       <= 6'd0;
         fail_q      <= 1'b0;
         armed_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_bad_q <= 1'b0;
         good_q      <= '0;
         bad_q       <= '0;
`ifdef MXRX_CHECK_FIRST_ERR_EN
         ferr_idx_q  <= 6'd0;
         ferr_data_q <= 8'd0;
         ferr_vld_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         fail_q      <= fail_d;
         armed_q     <= armed_d;
         frame_ok_q  <= frame_ok_d;
         frame_bad_q <= frame_bad_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
`ifdef MXRX_CHECK_FIRST_ERR_EN
         ferr_idx_q  <= ferr_idx_d;
         ferr_data_q <= ferr_data_d;
         ferr_vld_q  <= ferr_vld_d;
`endif
      end
   end

   assign busy       = (state_q == ST_RECV) || (state_q == ST_EVAL);
   assign frame_ok   = frame_ok_q;
   assign frame_bad  = frame_bad_q;
   assign good_count = good_q;
   assign bad_count  = bad_q;
`ifdef MXRX_CHECK_FIRST_ERR_EN
   assign first_err_idx   = ferr_idx_q;
   assign first_err_data  = ferr_data_q;
   assign first_err_valid = ferr_vld_q;
`endif

endmodule
